multicycle_ctrl: RTL and testbench
==================================

# multicycle_ctrl

Multi-cycle control FSM for the CPU datapath: sequences one shared ALU, one unified memory port and the register file through IF/ID/EX/MEM/WB steps for the supported ISA (R-type, BEQ, BNE, ADDI, ORI, LUI, LW, SW). It replaces the purely combinational opcode decode with a stateful sequencer that waits on a memory ready handshake. It also flags illegal opcodes, counts retired instructions and traps on memory timeouts.

## Interface
- MEM_WAIT_MAX, 15: maximum consecutive wait cycles with mem_ready_i low before trapping; 0 disables the timeout.
- clk_i  in  1  clock; all state changes on the rising edge.
- rst_i  in  1  asynchronous reset, active-high.
- instr_op_i  in  6  opcode field of the instruction register.
- zero_i  in  1  ALU zero flag.
- mem_ready_i  in  1  memory transfer complete this cycle.
- PCWrite_o, IRWrite_o, IorD_o, MemRead_o, MemWrite_o, MemtoReg_o, RegDst_o, RegWrite_o, ALUSrcA_o, SignExtend_o  out  1 each  datapath controls. SignExtend_o=1 selects zero-extension (ORI).
- ALUSrcB_o  out  2  00 rt, 01 const 4, 10 imm, 11 imm<<2.
- ALU_op_o  out  3  000 add, 010 branch, 100 R-type, 101 ORI, 111 LUI.
- PCSource_o  out  2  00 ALU result, 01 ALUOut register.
- illegal_o  out  1  one-cycle pulse on an unsupported opcode.
- err_o  out  1  sticky memory-timeout trap.
- instr_count_o  out  16  number of retired legal instructions.
- state_o  out  3  current state, for debug.

## Operation
- States: S_RST=0, S_IF=1, S_ID=2, S_EX=3, S_MEM=4, S_WB=5, S_ERR=7.
- Outputs are Moore-decoded from state plus the latched opcode op_q, with two exceptions that also depend on inputs: PCWrite_o/IRWrite_o in S_IF (mem_ready_i) and PCWrite_o in S_EX (zero_i).
- Any output not listed for a state is 0.
- S_RST: all outputs 0. Next state S_IF.
- S_IF: MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALU_op=000, PCSource=00.
  - IRWrite=PCWrite=mem_ready_i.
  - On mem_ready_i go to S_ID; otherwise stay.
- S_ID: ALUSrcA=0, ALUSrcB=11, ALU_op=000 (branch target into ALUOut). op_q <= instr_op_i.
  - Supported opcode: go to S_EX.
  - Otherwise: illegal_o=1, no retire, go to S_IF.
- S_EX, by op_q:
  - R-type: A=1, B=00, op=100, then S_WB.
  - ADDI: A=1, B=10, op=000, then S_WB.
  - LW/SW: A=1, B=10, op=000, then S_MEM.
  - ORI: A=1, B=10, op=101, SignExtend=1, then S_WB.
  - LUI: A=1, B=10, op=111, then S_WB.
  - BEQ/BNE: A=1, B=00, op=010, PCSource=01. PCWrite=zero_i for BEQ, ~zero_i for BNE. Retire, then S_IF.
- S_MEM: IorD=1, MemRead=1 for LW, MemWrite=1 for SW. Hold until mem_ready_i.
  - LW then goes to S_WB.
  - SW retires, then S_IF.
- S_WB: RegWrite=1; RegDst=1 for R-type; MemtoReg=1 for LW. Retire, then S_IF.
- Retire: instr_count_o increments by 1 and wraps 0xFFFF->0.
- Wait counter:
  - Cleared on entry to S_IF/S_MEM.
  - Increments each S_IF/S_MEM cycle with mem_ready_i=0.
  - When it reaches MEM_WAIT_MAX (and MEM_WAIT_MAX≠0) with ready still low, go to S_ERR instead.
- S_ERR: all datapath outputs 0, err_o=1. Held until rst_i.
- Reset (async, any state, mid-transfer included): state S_RST, op_q=0, counters 0, every output 0.

## Timing
- Cycles per instruction with zero wait states: branch 3, R/ADDI/ORI/LUI 4, SW 4, LW 5.
- Each memory wait cycle adds exactly 1 cycle.
- After rst_i deasserts: S_RST for 1 cycle, then S_IF; the first instruction fetch completes at the earliest on the 2nd edge.
- mem_ready_i is sampled only in S_IF/S_MEM; it is ignored in every other state.
- Timeout: with MEM_WAIT_MAX=N, the state is S_ERR on the edge after the N-th consecutive not-ready cycle. Ready arriving in the same cycle as the limit is reached wins.
- instr_count_o updates on the edge that leaves the retiring state.
- illegal_o is high during the S_ID cycle only.

## Test plan
- ADDI, mem_ready_i tied 1 → states 1,2,3,5,1. RegWrite=1 only in S_WB, ALUSrcB=10 in S_EX. instr_count_o goes 0→1 after 4 cycles.
- LW with mem_ready_i low for 3 cycles in S_MEM → S_MEM held 4 cycles. MemRead=IorD=1 throughout. MemtoReg=RegWrite=1 in S_WB. Total 8 cycles.
- BEQ zero_i=1, then BNE zero_i=1 → PCWrite=1 and PCSource=01 in S_EX for the first only. Both retire in 3 cycles.
- Opcode 6'd2 → illegal_o one-cycle pulse in S_ID, back to S_IF, count unchanged, RegWrite/MemWrite never asserted.
- MEM_WAIT_MAX=15 with mem_ready_i held 0 in S_IF → S_ERR after 15 wait cycles, err_o=1 and sticky. rst_i pulse → all outputs 0, state_o=0.
- rst_i asserted asynchronously mid-SW in S_MEM → MemWrite_o drops immediately, instr_count_o=0, restart from S_RST.

Source files
------------

// File: rtl/multicycle_ctrl.sv
// Multi-cycle control sequencer: IF/ID/EX/MEM/WB over a shared ALU and
// unified memory port, with illegal-opcode flag, retire counter and timeout trap.
module multicycle_ctrl #(
  parameter int MEM_WAIT_MAX = 15
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [5:0]  instr_op_i,
  input  logic        zero_i,
  input  logic        mem_ready_i,
  output logic        PCWrite_o,
  output logic        IRWrite_o,
  output logic        IorD_o,
  output logic        MemRead_o,
  output logic        MemWrite_o,
  output logic        MemtoReg_o,
  output logic        RegDst_o,
  output logic        RegWrite_o,
  output logic        ALUSrcA_o,
  output logic        SignExtend_o,
  output logic [1:0]  ALUSrcB_o,
  output logic [2:0]  ALU_op_o,
  output logic [1:0]  PCSource_o,
  output logic        illegal_o,
  output logic        err_o,
  output logic [15:0] instr_count_o,
  output logic [2:0]  state_o
);

  typedef enum logic [2:0] {
    S_RST = 3'd0,
    S_IF  = 3'd1,
    S_ID  = 3'd2,
    S_EX  = 3'd3,
    S_MEM = 3'd4,
    S_WB  = 3'd5,
    S_ERR = 3'd7
  } state_t;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_BNE  = 6'b000101;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_ORI  = 6'b001101;
  localparam logic [5:0] OP_LUI  = 6'b001111;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;

  localparam logic [15:0] WAIT_LAST = 16'(MEM_WAIT_MAX - 1);
  localparam logic        WAIT_EN   = (MEM_WAIT_MAX != 0);

  state_t      r_state;
  state_t      w_next;
  logic [5:0]  r_op;
  logic [15:0] r_wait;
  logic [15:0] r_cnt;
  logic        w_legal;
  logic        w_retire;
  logic        w_mem_phase;
  logic        w_timeout;

  always_comb begin
    w_legal = 1'b0;
    case (instr_op_i)
      OP_R, OP_BEQ, OP_BNE, OP_ADDI,
      OP_ORI, OP_LUI, OP_LW, OP_SW: w_legal = 1'b1;
      default:                      w_legal = 1'b0;
    endcase
  end

  assign w_mem_phase = (r_state == S_IF) || (r_state == S_MEM);
  // A ready arriving on the limit cycle takes priority over the trap
  assign w_timeout = WAIT_EN && !mem_ready_i && (r_wait == WAIT_LAST);

  always_comb begin
    w_next       = r_state;
    w_retire     = 1'b0;
    PCWrite_o    = 1'b0;
    IRWrite_o    = 1'b0;
    IorD_o       = 1'b0;
    MemRead_o    = 1'b0;
    MemWrite_o   = 1'b0;
    MemtoReg_o   = 1'b0;
    RegDst_o     = 1'b0;
    RegWrite_o   = 1'b0;
    ALUSrcA_o    = 1'b0;
    SignExtend_o = 1'b0;
    ALUSrcB_o    = 2'b00;
    ALU_op_o     = 3'b000;
    PCSource_o   = 2'b00;
    illegal_o    = 1'b0;
    case (r_state)
      S_RST: w_next = S_IF;
      S_IF: begin
        MemRead_o = 1'b1;
        ALUSrcB_o = 2'b01;
        IRWrite_o = mem_ready_i;
        PCWrite_o = mem_ready_i;
        if (mem_ready_i)
          w_next = S_ID;
        else if (w_timeout)
          w_next = S_ERR;
      end
      S_ID: begin
        ALUSrcB_o = 2'b11;
        if (w_legal) begin
          w_next = S_EX;
        end else begin
          illegal_o = 1'b1;
          w_next    = S_IF;
        end
      end
      S_EX: begin
        ALUSrcA_o = 1'b1;
        case (r_op)
          OP_R: begin
            ALU_op_o = 3'b100;
            w_next   = S_WB;
          end
          OP_ADDI: begin
            ALUSrcB_o = 2'b10;
            w_next    = S_WB;
          end
          OP_LW, OP_SW: begin
            ALUSrcB_o = 2'b10;
            w_next    = S_MEM;
          end
          OP_ORI: begin
            ALUSrcB_o    = 2'b10;
            ALU_op_o     = 3'b101;
            SignExtend_o = 1'b1;
            w_next       = S_WB;
          end
          OP_LUI: begin
            ALUSrcB_o = 2'b10;
            ALU_op_o  = 3'b111;
            w_next    = S_WB;
          end
          OP_BEQ, OP_BNE: begin
            ALU_op_o   = 3'b010;
            PCSource_o = 2'b01;
            PCWrite_o  = (r_op == OP_BEQ) ? zero_i : ~zero_i;
            w_retire   = 1'b1;
            w_next     = S_IF;
          end
          default: w_next = S_IF;
        endcase
      end
      S_MEM: begin
        IorD_o     = 1'b1;
        MemRead_o  = (r_op == OP_LW);
        MemWrite_o = (r_op == OP_SW);
        if (mem_ready_i) begin
          if (r_op == OP_LW) begin
            w_next = S_WB;
          end else begin
            w_retire = 1'b1;
            w_next   = S_IF;
          end
        end else if (w_timeout) begin
          w_next = S_ERR;
        end
      end
      S_WB: begin
        RegWrite_o = 1'b1;
        RegDst_o   = (r_op == OP_R);
        MemtoReg_o = (r_op == OP_LW);
        w_retire   = 1'b1;
        w_next     = S_IF;
      end
      S_ERR:   w_next = S_ERR;
      default: w_next = S_RST;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= S_RST;
      r_op    <= 6'd0;
      r_wait  <= 16'd0;
      r_cnt   <= 16'd0;
    end else begin
      r_state <= w_next;
      if (r_state == S_ID)
        r_op <= instr_op_i;
      if (w_mem_phase && !mem_ready_i) begin
        if (r_wait != 16'hFFFF)
          r_wait <= r_wait + 16'd1;
      end else begin
        r_wait <= 16'd0;
      end
      if (w_retire)
        r_cnt <= r_cnt + 16'd1;
    end
  end

  assign err_o         = (r_state == S_ERR);
  assign instr_count_o = r_cnt;
  assign state_o       = r_state;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed vector bench for multicycle_ctrl: instruction sequences,
// memory waits, illegal opcode, timeout trap and asynchronous reset.
module tb_multicycle_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  op;
  logic        zero;
  logic        rdy;
  logic        PCWrite, IRWrite, IorD, MemRead, MemWrite;
  logic        MemtoReg, RegDst, RegWrite, ALUSrcA, SignExtend;
  logic [1:0]  ALUSrcB;
  logic [2:0]  ALU_op;
  logic [1:0]  PCSource;
  logic        illegal, err;
  logic [15:0] cnt;
  logic [2:0]  state;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  multicycle_ctrl #(.MEM_WAIT_MAX(15)) dut (
    .clk_i(clk), .rst_i(rst), .instr_op_i(op), .zero_i(zero),
    .mem_ready_i(rdy),
    .PCWrite_o(PCWrite), .IRWrite_o(IRWrite), .IorD_o(IorD),
    .MemRead_o(MemRead), .MemWrite_o(MemWrite), .MemtoReg_o(MemtoReg),
    .RegDst_o(RegDst), .RegWrite_o(RegWrite), .ALUSrcA_o(ALUSrcA),
    .SignExtend_o(SignExtend), .ALUSrcB_o(ALUSrcB), .ALU_op_o(ALU_op),
    .PCSource_o(PCSource), .illegal_o(illegal), .err_o(err),
    .instr_count_o(cnt), .state_o(state)
  );

  localparam logic [5:0] R = 6'b000000, BEQ = 6'b000100, BNE = 6'b000101;
  localparam logic [5:0] ADDI = 6'b001000, ORI = 6'b001101, LUI = 6'b001111;
  localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, BAD = 6'd2;

  // {PCW,IRW,IorD,MR,MW,M2R,RDst,RW,SrcA,SExt,SrcB[2],ALUop[3],PCSrc[2]}
  localparam logic [16:0] C_0    = 17'b0_0_0_0_0_0_0_0_0_0_00_000_00;
  localparam logic [16:0] C_IFR  = 17'b1_1_0_1_0_0_0_0_0_0_01_000_00;
  localparam logic [16:0] C_IFW  = 17'b0_0_0_1_0_0_0_0_0_0_01_000_00;
  localparam logic [16:0] C_ID   = 17'b0_0_0_0_0_0_0_0_0_0_11_000_00;
  localparam logic [16:0] C_EXI  = 17'b0_0_0_0_0_0_0_0_1_0_10_000_00;
  localparam logic [16:0] C_EXR  = 17'b0_0_0_0_0_0_0_0_1_0_00_100_00;
  localparam logic [16:0] C_EXO  = 17'b0_0_0_0_0_0_0_0_1_1_10_101_00;
  localparam logic [16:0] C_EXL  = 17'b0_0_0_0_0_0_0_0_1_0_10_111_00;
  localparam logic [16:0] C_BT   = 17'b1_0_0_0_0_0_0_0_1_0_00_010_01;
  localparam logic [16:0] C_BN   = 17'b0_0_0_0_0_0_0_0_1_0_00_010_01;
  localparam logic [16:0] C_MLW  = 17'b0_0_1_1_0_0_0_0_0_0_00_000_00;
  localparam logic [16:0] C_MSW  = 17'b0_0_1_0_1_0_0_0_0_0_00_000_00;
  localparam logic [16:0] C_WB   = 17'b0_0_0_0_0_0_0_1_0_0_00_000_00;
  localparam logic [16:0] C_WBR  = 17'b0_0_0_0_0_0_1_1_0_0_00_000_00;
  localparam logic [16:0] C_WBL  = 17'b0_0_0_0_0_1_0_1_0_0_00_000_00;

  typedef struct packed {
    logic [5:0]  op;
    logic        z;
    logic        r;
    logic [2:0]  st;
    logic [16:0] ctl;
    logic        ill;
    logic        err;
    logic [15:0] cnt;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t v(logic [5:0] o, logic z, logic r, logic [2:0] s,
                             logic [16:0] c, logic il, logic e, logic [15:0] n);
    vec_t t;
    t = '{op: o, z: z, r: r, st: s, ctl: c, ill: il, err: e, cnt: n};
    return t;
  endfunction

  task automatic check(string name, logic [2:0] s, logic [16:0] c,
                       logic il, logic e, logic [15:0] n);
    logic [37:0] act, exp;
    act = {state, PCWrite, IRWrite, IorD, MemRead, MemWrite, MemtoReg,
           RegDst, RegWrite, ALUSrcA, SignExtend, ALUSrcB, ALU_op,
           PCSource, illegal, err, cnt};
    exp = {s, c, il, e, n};
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got st=%0d ctl=%b ill=%b err=%b cnt=%0d, want st=%0d ctl=%b ill=%b err=%b cnt=%0d",
               name, act[37:35], act[34:18], act[17], act[16], act[15:0],
               s, c, il, e, n);
    end
  endtask

  // Drive inputs, check between edges, then let one rising edge pass
  task automatic apply(string name, vec_t t);
    op = t.op; zero = t.z; rdy = t.r;
    #1;
    check(name, t.st, t.ctl, t.ill, t.err, t.cnt);
    @(posedge clk);
    #2;
  endtask

  initial begin
    rst = 1'b1; op = '0; zero = 1'b0; rdy = 1'b0;

    // ADDI with ready ignored outside IF/MEM
    tbl.push_back(v(R,    0, 1, 0, C_0,   0, 0, 0));
    tbl.push_back(v(ADDI, 0, 1, 1, C_IFR, 0, 0, 0));
    tbl.push_back(v(ADDI, 0, 0, 2, C_ID,  0, 0, 0));
    tbl.push_back(v(ADDI, 0, 0, 3, C_EXI, 0, 0, 0));
    tbl.push_back(v(ADDI, 0, 0, 5, C_WB,  0, 0, 0));
    // R-type
    tbl.push_back(v(R,    0, 1, 1, C_IFR, 0, 0, 1));
    tbl.push_back(v(R,    0, 1, 2, C_ID,  0, 0, 1));
    tbl.push_back(v(R,    0, 1, 3, C_EXR, 0, 0, 1));
    tbl.push_back(v(R,    0, 1, 5, C_WBR, 0, 0, 1));
    // ORI
    tbl.push_back(v(ORI,  0, 1, 1, C_IFR, 0, 0, 2));
    tbl.push_back(v(ORI,  0, 1, 2, C_ID,  0, 0, 2));
    tbl.push_back(v(ORI,  0, 1, 3, C_EXO, 0, 0, 2));
    tbl.push_back(v(ORI,  0, 1, 5, C_WB,  0, 0, 2));
    // LUI
    tbl.push_back(v(LUI,  0, 1, 1, C_IFR, 0, 0, 3));
    tbl.push_back(v(LUI,  0, 1, 2, C_ID,  0, 0, 3));
    tbl.push_back(v(LUI,  0, 1, 3, C_EXL, 0, 0, 3));
    tbl.push_back(v(LUI,  0, 1, 5, C_WB,  0, 0, 3));
    // LW with three memory wait cycles
    tbl.push_back(v(LW,   0, 1, 1, C_IFR, 0, 0, 4));
    tbl.push_back(v(LW,   0, 1, 2, C_ID,  0, 0, 4));
    tbl.push_back(v(LW,   0, 1, 3, C_EXI, 0, 0, 4));
    tbl.push_back(v(LW,   0, 0, 4, C_MLW, 0, 0, 4));
    tbl.push_back(v(LW,   0, 0, 4, C_MLW, 0, 0, 4));
    tbl.push_back(v(LW,   0, 0, 4, C_MLW, 0, 0, 4));
    tbl.push_back(v(LW,   0, 1, 4, C_MLW, 0, 0, 4));
    tbl.push_back(v(LW,   0, 1, 5, C_WBL, 0, 0, 4));
    // SW with one fetch wait cycle
    tbl.push_back(v(SW,   0, 0, 1, C_IFW, 0, 0, 5));
    tbl.push_back(v(SW,   0, 1, 1, C_IFR, 0, 0, 5));
    tbl.push_back(v(SW,   0, 1, 2, C_ID,  0, 0, 5));
    tbl.push_back(v(SW,   0, 1, 3, C_EXI, 0, 0, 5));
    tbl.push_back(v(SW,   0, 1, 4, C_MSW, 0, 0, 5));
    // BEQ taken, BNE not taken, BNE taken
    tbl.push_back(v(BEQ,  1, 1, 1, C_IFR, 0, 0, 6));
    tbl.push_back(v(BEQ,  1, 1, 2, C_ID,  0, 0, 6));
    tbl.push_back(v(BEQ,  1, 1, 3, C_BT,  0, 0, 6));
    tbl.push_back(v(BNE,  1, 1, 1, C_IFR, 0, 0, 7));
    tbl.push_back(v(BNE,  1, 1, 2, C_ID,  0, 0, 7));
    tbl.push_back(v(BNE,  1, 1, 3, C_BN,  0, 0, 7));
    tbl.push_back(v(BNE,  0, 1, 1, C_IFR, 0, 0, 8));
    tbl.push_back(v(BNE,  0, 1, 2, C_ID,  0, 0, 8));
    tbl.push_back(v(BNE,  0, 1, 3, C_BT,  0, 0, 8));
    // Illegal opcode, then ADDI
    tbl.push_back(v(BAD,  0, 1, 1, C_IFR, 0, 0, 9));
    tbl.push_back(v(BAD,  0, 1, 2, C_ID,  1, 0, 9));
    tbl.push_back(v(ADDI, 0, 1, 1, C_IFR, 0, 0, 9));
    tbl.push_back(v(ADDI, 0, 1, 2, C_ID,  0, 0, 9));
    tbl.push_back(v(ADDI, 0, 1, 3, C_EXI, 0, 0, 9));
    tbl.push_back(v(ADDI, 0, 1, 5, C_WB,  0, 0, 9));
    // First of fifteen not-ready fetch cycles
    tbl.push_back(v(R,    0, 0, 1, C_IFW, 0, 0, 10));

    #2;
    check("reset", 3'd0, C_0, 1'b0, 1'b0, 16'd0);
    #5;
    rst = 1'b0;

    foreach (tbl[i]) apply($sformatf("vec%0d", i), tbl[i]);

    for (int i = 0; i < 14; i++)
      apply($sformatf("if_wait%0d", i + 2), v(R, 0, 0, 1, C_IFW, 0, 0, 10));
    for (int i = 0; i < 3; i++)
      apply($sformatf("err_sticky%0d", i), v(R, 0, 1, 7, C_0, 0, 1, 10));

    rst = 1'b1;
    #1;
    check("err_reset", 3'd0, C_0, 1'b0, 1'b0, 16'd0);
    #1;
    rst = 1'b0;

    apply("rst_state", v(R, 0, 0, 0, C_0, 0, 0, 0));
    for (int i = 0; i < 14; i++)
      apply($sformatf("wait_b%0d", i + 1), v(R, 0, 0, 1, C_IFW, 0, 0, 0));
    apply("ready_at_limit", v(ADDI, 0, 1, 1, C_IFR, 0, 0, 0));
    apply("addi2_id", v(ADDI, 0, 1, 2, C_ID,  0, 0, 0));
    apply("addi2_ex", v(ADDI, 0, 1, 3, C_EXI, 0, 0, 0));
    apply("addi2_wb", v(ADDI, 0, 1, 5, C_WB,  0, 0, 0));
    apply("sw_if",    v(SW,   0, 1, 1, C_IFR, 0, 0, 1));
    apply("sw_id",    v(SW,   0, 1, 2, C_ID,  0, 0, 1));
    apply("sw_ex",    v(SW,   0, 1, 3, C_EXI, 0, 0, 1));
    apply("sw_mem",   v(SW,   0, 0, 4, C_MSW, 0, 0, 1));
    check("sw_mem_hold", 3'd4, C_MSW, 1'b0, 1'b0, 16'd1);

    rst = 1'b1;
    #1;
    check("async_rst", 3'd0, C_0, 1'b0, 1'b0, 16'd0);
    #1;
    rst = 1'b0;
    apply("restart_rst", v(SW, 0, 1, 0, C_0,   0, 0, 0));
    apply("restart_if",  v(SW, 0, 1, 1, C_IFR, 0, 0, 0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
